// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: FSM state codes, default sizing
// and the per-stage control bundle.
package pipeline_ctrl_pkg;

  localparam logic [1:0] StInit     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StMemWait  = 2'd2;
  localparam logic [1:0] StRedirect = 2'd3;

  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefMemTimeout = 1024;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CtrlRun    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CtrlInit   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  // Front of the pipe held, WB keeps draining bubbles.
  localparam ctrl_t CtrlFreeze = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_perf.sv
// Wrap-around performance counters for stall cycles and accepted redirects.
module pipeline_ctrl_perf
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc) stall_q <= stall_q + 1'b1;
      if (flush_inc) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges load-use stalls, data-memory waits and EX redirects
// into stage enables/flushes. Optional perf counters under PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 0,
  parameter int unsigned MEM_TIMEOUT      = DefMemTimeout,
  parameter int unsigned CNT_W            = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned    WdW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0]     Bubbles = 4'(REDIRECT_BUBBLES);
  localparam logic [WdW-1:0] WdMax   = WdW'(MEM_TIMEOUT);

  logic [1:0]     state_q, state_d;
  logic [3:0]     bub_q, bub_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           mfreeze;
  ctrl_t          ctrl;

  assign mfreeze = dmem_req & ~dmem_ready;

  always_comb begin
    ctrl    = CtrlRun;
    state_d = state_q;
    bub_d   = bub_q;
    wd_d    = wd_q;
    err_d   = err_q;
    if (state_q == StInit) begin
      ctrl    = CtrlInit;
      state_d = StRun;
    end else if (mfreeze) begin
      // Redirect stays pending in EX; bubble counter holds until release.
      ctrl    = CtrlFreeze;
      state_d = StMemWait;
      if (state_q == StMemWait && wd_q != WdMax) begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WdMax) err_d = 1'b1;
      end
    end else begin
      wd_d    = '0;
      state_d = StRun;
      if (redirect) begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        bub_d            = Bubbles;
        state_d          = (Bubbles != 4'd0) ? StRedirect : StRun;
      end else if (state_q == StRedirect) begin
        // ID already holds a bubble, so load_use has nothing to stall.
        ctrl.if_id_flush = 1'b1;
        bub_d            = bub_q - 1'b1;
        state_d          = (bub_q == 4'd1) ? StRun : StRedirect;
      end else begin
        if (state_q == StMemWait && bub_q != 4'd0) state_d = StRedirect;
        if (load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      bub_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_err      = err_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = (state_q != StInit) & ~ctrl.pc_en;
  assign flush_inc = (state_q != StInit) & ~mfreeze & redirect;

  pipeline_ctrl_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_inc   (stall_inc),
    .flush_inc   (flush_inc),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// expectations from a behavioural model, compared by an independent monitor.
module tb_pipeline_ctrl;

  localparam int unsigned B  = 2;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, redirect = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_ctrl #(
    .REDIRECT_BUBBLES(B),
    .MEM_TIMEOUT     (TO),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_use    (load_use),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .redirect    (redirect),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .mem_wb_flush(mem_wb_flush),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]    ctl;  // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,memwb_f, err}
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: pipeline mode described by flags and counts.
  bit          m_init, m_wait, m_err;
  int          m_bub, m_wd;
  int unsigned m_stall, m_flush;

  function automatic void model_reset();
    m_init = 1; m_wait = 0; m_err = 0;
    m_bub = 0; m_wd = 0; m_stall = 0; m_flush = 0;
  endfunction

  function automatic exp_t make_exp(input bit pc, ifid, idex, exmem, memwb,
                                    input bit fi, fx, fw);
    exp_t e;
    e.ctl = {pc, ifid, idex, exmem, memwb, fi, fx, fw, m_err};
`ifdef PIPELINE_CTRL_PERF_EN
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    return e;
  endfunction

  // Expected outputs for this cycle, then advance the model over the edge.
  function automatic exp_t model_step(input bit lu, req, rdy, redir);
    exp_t e;
    bit released;
    if (m_init) begin
      e = make_exp(0, 0, 0, 0, 0, 1, 1, 1);
      m_init = 0;
    end else if (req && !rdy) begin
      e = make_exp(0, 0, 0, 0, 1, 0, 0, 1);
      m_stall++;
      if (m_wait && m_wd < int'(TO)) begin
        m_wd++;
        if (m_wd == int'(TO)) m_err = 1;
      end
      m_wait = 1;
    end else begin
      released = m_wait;
      m_wait = 0;
      m_wd = 0;
      if (redir) begin
        e = make_exp(1, 1, 1, 1, 1, 1, 1, 0);
        m_flush++;
        m_bub = B;
      end else if (m_bub > 0 && !released) begin
        e = make_exp(1, 1, 1, 1, 1, 1, 0, 0);
        m_bub--;
      end else if (lu) begin
        e = make_exp(0, 0, 1, 1, 1, 0, 1, 0);
        m_stall++;
      end else begin
        e = make_exp(1, 1, 1, 1, 1, 0, 0, 0);
      end
    end
    return e;
  endfunction

  task automatic cycle(input bit lu, req, rdy, redir);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_use = lu; dmem_req = req; dmem_ready = rdy; redirect = redir;
    q.push_back(model_step(lu, req, rdy, redir));
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    q.push_back(make_exp(0, 0, 0, 0, 0, 1, 1, 1));
  endtask

  // Monitor: every cycle the DUT presents a full control word.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_err};
        n_tests++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctrl cycle %0d: got %b expected %b", cyc, act, e.ctl);
        end
        n_tests++;
        if (stall_cycles !== e.stall) begin
          n_fail++;
          $display("FAIL stall_cycles cycle %0d: got %0d expected %0d",
                   cyc, stall_cycles, e.stall);
        end
        n_tests++;
        if (flush_count !== e.flush) begin
          n_fail++;
          $display("FAIL flush_count cycle %0d: got %0d expected %0d",
                   cyc, flush_count, e.flush);
        end
      end
    end
  end

  initial begin
    model_reset();
    reset_cycle();
    repeat (3) cycle(0, 0, 0, 0);
    // single load-use stall
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // 3-cycle memory wait, release on the 4th
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    // redirect held across a 2-cycle wait, then bubbles
    repeat (2) cycle(0, 1, 0, 1);
    cycle(0, 1, 1, 1);
    repeat (3) cycle(1, 0, 0, 0);
    // redirect beats load_use
    cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    // watchdog timeout, error sticks past release
    repeat (7) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    // reset mid-wait
    repeat (2) cycle(0, 1, 0, 0);
    reset_cycle();
    repeat (3) cycle(0, 0, 0, 0);
    // random traffic with occasional long waits and resets
    for (int i = 0; i < 3000; i++) begin
      bit lu, req, rdy, rd;
      if ($urandom_range(0, 299) == 0) begin
        reset_cycle();
      end else begin
        lu  = ($urandom_range(0, 4) == 0);
        req = ($urandom_range(0, 2) == 0);
        rdy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 1));
        rd  = ($urandom_range(0, 6) == 0);
        cycle(lu, req, rdy, rd);
      end
    end
    cycle(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 5-stage core. It combines three inputs into one set of per-stage register enables, flushes and PC control: the load-use stall request from the hazard detector, the data-memory wait handshake, and the EX-stage branch/jump redirect. A small FSM handles multi-cycle memory waits, post-redirect fetch bubbles and a memory-wait watchdog.

## Interface
- REDIRECT_BUBBLES, 0: extra cycles IF/ID stays flushed after a redirect (0–15).
- MEM_TIMEOUT, 1024: memory-wait cycles before `mem_err` sets (≥2).
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- load_use  in  1  load-use stall request from hazard detector
- dmem_req  in  1  MEM stage holds a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- redirect  in  1  EX-stage taken branch/jump; PC mux selects target
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, valid=0)
- mem_err  out  1  sticky watchdog error
- stall_cycles, flush_count  out  CNT_W each  perf counters (macro only; 0 otherwise)

## Operation
- States: INIT, RUN, MEM_WAIT, REDIRECT.
- Reset state INIT; bubble counter 0; watchdog 0; `mem_err` 0; perf counters 0.
- Outputs are combinational from state plus current inputs (Mealy). Next state is registered.
- INIT: all enables 0; all flushes 1. Next state RUN unconditionally.
- Signal `mfreeze` = dmem_req & !dmem_ready. Priority: mfreeze > redirect > load_use.
- mfreeze, in any state except INIT:
  - pc/if_id/id_ex/ex_mem enables 0; mem_wb_en 1 with mem_wb_flush 1.
  - Next state MEM_WAIT.
  - Bubble counter frozen.
  - `redirect` is ignored while frozen. It stays asserted because EX is held, so it is taken on release.
- MEM_WAIT:
  - Watchdog increments each cycle.
  - When the watchdog reaches MEM_TIMEOUT, `mem_err` sets and holds until reset. The FSM keeps waiting.
  - When dmem_ready=1: outputs evaluate as in RUN that cycle and the watchdog clears.
  - Next state is REDIRECT if the bubble counter ≠ 0, else RUN.
- Redirect without mfreeze:
  - All enables 1; if_id_flush=1; id_ex_flush=1.
  - Bubble counter loads REDIRECT_BUBBLES.
  - Next state REDIRECT if REDIRECT_BUBBLES>0, else RUN.
- Load_use without mfreeze or redirect:
  - pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1; ex_mem/mem_wb enables 1.
  - Lasts exactly the cycles `load_use` is high (normally one).
- REDIRECT:
  - As RUN, plus if_id_flush=1.
  - Counter decrements; leaves to RUN the cycle it reaches 0.
  - A new redirect reloads the counter.
  - load_use is ignored, because ID holds a bubble.
- RUN, no request: all enables 1, all flushes 0.

## Timing
- Zero-cycle control latency: requests act on the same clock edge.
- A memory wait of N cycles (dmem_ready low N cycles) freezes the front for exactly N cycles. It also inserts N WB bubbles.
- A redirect costs 2 + REDIRECT_BUBBLES fetch slots.
- Asserting rst_n low mid-wait returns to INIT immediately. Counters and `mem_err` clear.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - `stall_cycles` counts cycles with pc_en=0 outside INIT.
  - `flush_count` counts accepted redirects.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs tie to 0 and no counter flops exist.

## Structure
- pipeline_ctrl_pkg holds the state enum (INIT=0, RUN=1, MEM_WAIT=2, REDIRECT=3) and the default CNT_W/MEM_TIMEOUT constants.
- One sub-module, pipeline_ctrl_perf, holds the two wrap-around counters. It is instantiated only under the macro.

## Test plan
- Reset release → one INIT cycle (all flush=1, enables=0), then RUN with all enables=1.
- load_use=1 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only; `stall_cycles` +1.
- dmem_req=1 with dmem_ready low 3 cycles → front enables 0 for 3 cycles, mem_wb_flush=1 for 3 cycles, release on the 4th; `stall_cycles` +3.
- redirect together with dmem wait of 2 cycles → no flush during the wait; on release if_id_flush=id_ex_flush=1. With REDIRECT_BUBBLES=2, if_id_flush stays 1 for 2 more cycles.
- redirect and load_use in the same cycle → flushes asserted, pc_en=1 (redirect wins); `flush_count` +1.
- MEM_TIMEOUT=4, dmem_ready held 0 → `mem_err`=1 after 4 MEM_WAIT cycles and stays 1 after later dmem_ready; clears only on rst_n low.
